// File: rtl/branch_pred_pkg.sv
// rtl/branch_pred_pkg.sv - shared constants and helpers for the pattern history table
//
// Counter-width limits, weakly-not-taken init value and the PC/GHR index hash.
package branch_pred_pkg;

  localparam int CTR_BITS_MIN = 2;
  localparam int CTR_BITS_MAX = 4;

  // Weakly-not-taken: the largest value whose MSB is still 0.
  function automatic logic [CTR_BITS_MAX-1:0] wnt_value(input int ctr_bits);
    return CTR_BITS_MAX'((1 << (ctr_bits - 1)) - 1);
  endfunction

  // Word-aligned PC bits XOR the history register. A ghr_bits of 0 masks
  // the history out entirely, giving plain bimodal indexing.
  function automatic logic [31:0] hash_index(input logic [31:0] pc,
                                             input logic [31:0] ghr,
                                             input int unsigned index_bits,
                                             input int unsigned ghr_bits);
    logic [31:0] imask;
    logic [31:0] gmask;
    imask = (32'd1 << index_bits) - 32'd1;
    gmask = (32'd1 << ghr_bits) - 32'd1;
    return ((pc >> 2) ^ (ghr & gmask)) & imask;
  endfunction

endpackage

// File: rtl/sat_ctr_next.sv
// rtl/sat_ctr_next.sv - combinational saturating up/down counter step
//
// Ports: cur (current counter), taken (outcome), nxt (counter after outcome).
module sat_ctr_next #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] cur,
  input  logic                taken,
  output logic [CTR_BITS-1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != {CTR_BITS{1'b1}}) nxt = cur + CTR_BITS'(1);
    end else begin
      if (cur != '0) nxt = cur - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_pht.sv
// rtl/branch_pht.sv - branch pattern history table with optional gshare indexing
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous clear of table, history and stats
//   pred_req/pred_pc  lookup request; result on pred_valid/pred_taken/pred_ctr next cycle
//   upd_valid/upd_pc/upd_taken/upd_mispred  resolved-branch training strobe
//   mispred_cnt       saturating count of reported mispredictions
module branch_pht
  import branch_pred_pkg::*;
#(
  parameter int CTR_BITS   = 2,
  parameter int INDEX_BITS = 6,
  parameter int GHR_BITS   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                pred_req,
  input  logic [31:0]         pred_pc,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [CTR_BITS-1:0] pred_ctr,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic                upd_taken,
  input  logic                upd_mispred,
  output logic [15:0]         mispred_cnt
);

  localparam int DEPTH = 1 << INDEX_BITS;
  // Keep at least one history flop so the bimodal build still elaborates;
  // hash_index masks it out when GHR_BITS is 0.
  localparam int GHR_W = (GHR_BITS > 0) ? GHR_BITS : 1;
  localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'(wnt_value(CTR_BITS));

  logic [CTR_BITS-1:0]   table_q [DEPTH];
  logic [GHR_W-1:0]      ghr;
  logic [INDEX_BITS-1:0] pred_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [CTR_BITS-1:0]   upd_cur;
  logic [CTR_BITS-1:0]   upd_next;
  logic [CTR_BITS-1:0]   lookup_ctr;

  // Both indices use the history as it stands at the start of the cycle.
  assign pred_idx = INDEX_BITS'(hash_index(pred_pc, 32'(ghr), INDEX_BITS, GHR_BITS));
  assign upd_idx  = INDEX_BITS'(hash_index(upd_pc, 32'(ghr), INDEX_BITS, GHR_BITS));
  assign upd_cur  = table_q[upd_idx];

  sat_ctr_next #(
    .CTR_BITS(CTR_BITS)
  ) u_sat_ctr_next (
    .cur  (upd_cur),
    .taken(upd_taken),
    .nxt  (upd_next)
  );

  // Write-through: a lookup colliding with this cycle's update sees the
  // counter value that the update is about to store.
  always_comb begin
    lookup_ctr = table_q[pred_idx];
    if (upd_valid && (upd_idx == pred_idx)) lookup_ctr = upd_next;
  end

  assign pred_taken = pred_ctr[CTR_BITS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= WNT;
      ghr         <= '0;
      pred_valid  <= 1'b0;
      pred_ctr    <= '0;
      mispred_cnt <= '0;
    end else if (flush) begin
      // pred_ctr is deliberately held: the output only moves on a valid lookup.
      for (int i = 0; i < DEPTH; i++) table_q[i] <= WNT;
      ghr         <= '0;
      pred_valid  <= 1'b0;
      mispred_cnt <= '0;
    end else begin
      pred_valid <= pred_req;
      if (pred_req) pred_ctr <= lookup_ctr;
      if (upd_valid) begin
        table_q[upd_idx] <= upd_next;
        ghr              <= GHR_W'({ghr, upd_taken});
        if (upd_mispred && (mispred_cnt != 16'hFFFF)) mispred_cnt <= mispred_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_pht.sv
// tb/tb_branch_pht.sv - self-checking bench for branch_pht (bimodal, gshare and 3-bit builds)
module tb_branch_pht;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush;
  logic        pred_req;
  logic [31:0] pred_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_mispred;

  logic        v0, t0, v1, t1, v2, t2;
  logic [1:0]  c0, c1;
  logic [2:0]  c2;
  logic [15:0] m0, m1, m2;

  branch_pht u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .pred_req(pred_req), .pred_pc(pred_pc),
    .pred_valid(v0), .pred_taken(t0), .pred_ctr(c0), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_mispred(upd_mispred), .mispred_cnt(m0)
  );

  branch_pht #(.GHR_BITS(4)) u_gsh (
    .clk(clk), .rst_n(rst_n), .flush(flush), .pred_req(pred_req), .pred_pc(pred_pc),
    .pred_valid(v1), .pred_taken(t1), .pred_ctr(c1), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_mispred(upd_mispred), .mispred_cnt(m1)
  );

  branch_pht #(.CTR_BITS(3)) u_c3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .pred_req(pred_req), .pred_pc(pred_pc),
    .pred_valid(v2), .pred_taken(t2), .pred_ctr(c2), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_mispred(upd_mispred), .mispred_cnt(m2)
  );

  typedef struct {
    int         due;
    logic [3:0] ctr;
    logic       taken;
    int         tag;
  } exp_t;

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic        um;
    logic        pr;
    logic [31:0] ppc;
    logic [3:0]  ectr;
    logic        etk;
  } vec_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   sel   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic       m_valid;
  logic       m_taken;
  logic [3:0] m_ctr;

  always_comb begin
    m_valid = v0;
    m_taken = t0;
    m_ctr   = {2'b00, c0};
    if (sel == 1) begin
      m_valid = v1;
      m_taken = t1;
      m_ctr   = {2'b00, c1};
    end else if (sel == 2) begin
      m_valid = v2;
      m_taken = t2;
      m_ctr   = {1'b0, c2};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted lookup must produce exactly one pred_valid
  // pulse in the following cycle carrying the queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (m_valid) begin
      if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL spurious_pred_valid: got 1, expected 0 (dut %0d cycle %0d)", sel, cyc);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("pred_ctr tag %0d", e.tag), 32'(m_ctr), 32'(e.ctr));
        check($sformatf("pred_taken tag %0d", e.tag), 32'(m_taken), 32'(e.taken));
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL missing_pred_valid tag %0d: got 0, expected 1", e.tag);
    end
  end

  task automatic drive(input logic uv, input logic [31:0] upc, input logic ut, input logic um,
                       input logic pr, input logic [31:0] ppc, input logic fl,
                       input logic [3:0] ectr, input logic etk, input int tag);
    exp_t e;
    upd_valid   = uv;
    upd_pc      = upc;
    upd_taken   = ut;
    upd_mispred = um;
    pred_req    = pr;
    pred_pc     = ppc;
    flush       = fl;
    if (pr && !fl) begin
      e.due   = cyc + 1;
      e.ctr   = ectr;
      e.taken = etk;
      e.tag   = tag;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    upd_valid   = 1'b0;
    upd_taken   = 1'b0;
    upd_mispred = 1'b0;
    pred_req    = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 0);
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [3:0] ectr, input logic etk, input int tag);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, pc, 1'b0, ectr, etk, tag);
  endtask

  task automatic update(input logic [31:0] pc, input logic tk, input logic mp);
    drive(1'b1, pc, tk, mp, 1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 0);
  endtask

  task automatic do_flush();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 4'd0, 1'b0, 0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic uv, input logic [31:0] upc, input logic ut, input logic um,
                              input logic pr, input logic [31:0] ppc, input logic [3:0] ectr,
                              input logic etk);
    vec_t v;
    v.uv = uv; v.upc = upc; v.ut = ut; v.um = um;
    v.pr = pr; v.ppc = ppc; v.ectr = ectr; v.etk = etk;
    return v;
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    vec_t vt[20];
    int   exp_mis;

    rst_n = 1'b0; flush = 1'b0; pred_req = 1'b0; pred_pc = 32'h0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0; upd_mispred = 1'b0;

    // Bimodal, 2-bit counters: index = pc[7:2]; 0x100 -> 0, 0x40/0x140/0x43 -> 16, 0x80 -> 32.
    vt[0]  = mk(1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h100,      4'd1, 1'b0);
    vt[1]  = mk(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0,        4'd0, 1'b0);
    vt[2]  = mk(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0,        4'd0, 1'b0);
    vt[3]  = mk(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0,        4'd0, 1'b0);
    vt[4]  = mk(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0,        4'd0, 1'b0);
    vt[5]  = mk(1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h100,      4'd3, 1'b1);
    vt[6]  = mk(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h100,      4'd2, 1'b1);
    vt[7]  = mk(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,        4'd0, 1'b0);
    vt[8]  = mk(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0,        4'd0, 1'b0);
    vt[9]  = mk(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,        4'd0, 1'b0);
    vt[10] = mk(1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h100,      4'd0, 1'b0);
    vt[11] = mk(1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h100,      4'd0, 1'b0);
    vt[12] = mk(1'b1, 32'h40,  1'b1, 1'b0, 1'b1, 32'h40,       4'd2, 1'b1);
    vt[13] = mk(1'b0, 32'h40,  1'b1, 1'b1, 1'b1, 32'h40,       4'd2, 1'b1);
    vt[14] = mk(1'b1, 32'h80,  1'b1, 1'b0, 1'b1, 32'h40,       4'd2, 1'b1);
    vt[15] = mk(1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h140,      4'd2, 1'b1);
    vt[16] = mk(1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h80,       4'd2, 1'b1);
    vt[17] = mk(1'b1, 32'h43,  1'b1, 1'b0, 1'b1, 32'h40,       4'd3, 1'b1);
    vt[18] = mk(1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h100,      4'd0, 1'b0);
    vt[19] = mk(1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 4'd1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_pred_valid", 32'(v0), 32'd0);
    check("rst_pred_ctr", 32'(c0), 32'd0);
    check("rst_pred_taken", 32'(t0), 32'd0);
    check("rst_mispred_cnt", 32'(m0), 32'd0);
    check("rst_c3_pred_ctr", 32'(c2), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven bimodal run.
    sel = 0;
    exp_mis = 0;
    for (int i = 0; i < 20; i++) begin
      drive(vt[i].uv, vt[i].upc, vt[i].ut, vt[i].um, vt[i].pr, vt[i].ppc, 1'b0,
            vt[i].ectr, vt[i].etk, i);
      if (vt[i].uv && vt[i].um) exp_mis++;
    end
    idle(2);
    check("hold_pred_valid", 32'(v0), 32'd0);
    check("hold_pred_ctr", 32'(c0), 32'(vt[19].ectr));
    check("table_mispred_cnt", 32'(m0), 32'(exp_mis));

    // Stats and flush.
    do_flush();
    check("flush_mispred_cnt", 32'(m0), 32'd0);
    for (int i = 0; i < 3; i++) update(32'h200, i[0], 1'b1);
    check("three_mispred_cnt", 32'(m0), 32'd3);
    drive(1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 4'd0, 1'b0, 100);
    check("flush_over_upd_cnt", 32'(m0), 32'd0);
    check("flush_pred_valid", 32'(v0), 32'd0);
    for (int i = 0; i < 64; i++) lookup(32'(i * 4), 4'd1, 1'b0, 200 + i);
    idle(2);

    // Reset asserted while a lookup is in flight.
    update(32'h100, 1'b1, 1'b0);
    update(32'h100, 1'b1, 1'b0);
    lookup(32'h100, 4'd3, 1'b1, 300);
    idle(1);
    pred_req = 1'b1;
    pred_pc  = 32'h100;
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_pred_valid", 32'(v0), 32'd0);
    check("midrst_pred_ctr", 32'(c0), 32'd0);
    check("midrst_pred_taken", 32'(t0), 32'd0);
    pred_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    lookup(32'h100, 4'd1, 1'b0, 301);
    idle(2);

    // Gshare, 4 history bits: T,T,N,T trains entries 0,1,3,6 and leaves GHR=1101.
    sel = 1;
    do_flush();
    update(32'h0, 1'b1, 1'b0);
    update(32'h0, 1'b1, 1'b0);
    update(32'h0, 1'b0, 1'b0);
    update(32'h0, 1'b1, 1'b0);
    lookup(32'h0,  4'd1, 1'b0, 400);
    lookup(32'h34, 4'd2, 1'b1, 401);
    lookup(32'h30, 4'd2, 1'b1, 402);
    lookup(32'h38, 4'd0, 1'b0, 403);
    lookup(32'h2C, 4'd2, 1'b1, 404);
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 4'd2, 1'b1, 405);
    lookup(32'h18, 4'd2, 1'b1, 406);
    idle(2);

    // 3-bit counters.
    sel = 2;
    reset_pulse();
    lookup(32'h100, 4'd3, 1'b0, 500);
    update(32'h100, 1'b1, 1'b0);
    lookup(32'h100, 4'd4, 1'b1, 501);
    update(32'h100, 1'b1, 1'b0);
    update(32'h100, 1'b1, 1'b0);
    drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 4'd7, 1'b1, 502);
    drive(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 4'd7, 1'b1, 503);
    drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 4'd6, 1'b1, 504);
    idle(2);

    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
